// File: rtl/zrc_hist_pkg.sv
// Shared definitions for the DDE histogram sequencer and mapper.
package zrc_hist_pkg;

    localparam int unsigned ST_W          = 3;
    localparam int unsigned DRAIN_CNT_W   = 8;
    localparam int unsigned DRAIN_CYC_DEF = 48;

    typedef enum logic [ST_W-1:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLR   = 3'd4
    } hist_st_e;

endpackage

// File: rtl/zrc_vld_shift.sv
// Parameterised 1-bit delay line; o_q is i_d delayed LAT cycles.
module zrc_vld_shift #(
    parameter int unsigned LAT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [LAT-1:0] r_sr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < int'(LAT); i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/zrc_hist_seq_ctrl.sv
// Per-frame ping-pong histogram sequencer: bank toggle at EOF, read sweep
// to the mapper, drain wait, then clear of the finished bank.
module zrc_hist_seq_ctrl
    import zrc_hist_pkg::*;
#(
    parameter int unsigned HIST_RAM_AW = 14,
    parameter int unsigned RAM_RD_LAT  = 2,
    parameter int unsigned DRAIN_CYC   = DRAIN_CYC_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_field_vld,
    input  logic                   i_enable,
    input  logic                   i_freeze,
    output logic                   o_bank_sel,
    output logic                   o_hist_rd_en,
    output logic [HIST_RAM_AW-1:0] o_hist_rd_addr,
    output logic                   o_hist_rd_vld,
    output logic                   o_clr_we,
    output logic                   o_clr_bank,
    output logic [HIST_RAM_AW-1:0] o_clr_addr,
    output logic                   o_map_update,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST   = DRAIN_CNT_W'(DRAIN_CYC - 1);
    localparam logic                   MAP_ON_ENTRY = (DRAIN_CYC == 1);
    localparam logic [HIST_RAM_AW-1:0] ADDR_LAST    = {HIST_RAM_AW{1'b1}};

    hist_st_e                r_state, w_state_nxt;
    logic                    r_field_d1;
    logic                    r_fin_bank, w_fin_bank_nxt;
    logic [DRAIN_CNT_W-1:0]  r_drain_cnt, w_drain_cnt_nxt;
    logic                    r_bank_sel, w_bank_sel_nxt;
    logic                    r_rd_en, w_rd_en_nxt;
    logic [HIST_RAM_AW-1:0]  r_rd_addr, w_rd_addr_nxt;
    logic                    r_clr_we, w_clr_we_nxt;
    logic                    r_clr_bank, w_clr_bank_nxt;
    logic [HIST_RAM_AW-1:0]  r_clr_addr, w_clr_addr_nxt;
    logic                    r_map_update, w_map_update_nxt;
    logic                    r_overrun, w_overrun_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    w_eof;
    logic                    w_rd_vld;

    assign w_eof = r_field_d1 & ~i_field_vld;

    // Output registers are loaded with the values for the state being entered.
    always_comb begin
        w_state_nxt      = r_state;
        w_fin_bank_nxt   = r_fin_bank;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_bank_sel_nxt   = r_bank_sel;
        w_rd_en_nxt      = 1'b0;
        w_rd_addr_nxt    = r_rd_addr;
        w_clr_we_nxt     = 1'b0;
        w_clr_bank_nxt   = r_clr_bank;
        w_clr_addr_nxt   = r_clr_addr;
        w_map_update_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (!r_clr_we) begin
                    w_clr_we_nxt   = 1'b1;
                    w_clr_bank_nxt = 1'b0;
                    w_clr_addr_nxt = '0;
                end else if (r_clr_addr == ADDR_LAST) begin
                    w_clr_addr_nxt = '0;
                    if (r_clr_bank) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_clr_we_nxt   = 1'b1;
                        w_clr_bank_nxt = 1'b1;
                    end
                end else begin
                    w_clr_we_nxt   = 1'b1;
                    w_clr_addr_nxt = r_clr_addr + HIST_RAM_AW'(1);
                end
            end
            ST_IDLE: begin
                if (w_eof && i_enable) begin
                    w_bank_sel_nxt = ~r_bank_sel;
                    w_fin_bank_nxt = r_bank_sel;
                    if (i_freeze) begin
                        w_state_nxt    = ST_CLR;
                        w_clr_we_nxt   = 1'b1;
                        w_clr_bank_nxt = r_bank_sel;
                        w_clr_addr_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_RD;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = '0;
                    end
                end
            end
            ST_RD: begin
                if (r_rd_addr == ADDR_LAST) begin
                    w_state_nxt      = ST_DRAIN;
                    w_rd_addr_nxt    = '0;
                    w_drain_cnt_nxt  = '0;
                    w_map_update_nxt = MAP_ON_ENTRY;
                end else begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_rd_addr + HIST_RAM_AW'(1);
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt    = ST_CLR;
                    w_clr_we_nxt   = 1'b1;
                    w_clr_bank_nxt = r_fin_bank;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_drain_cnt_nxt  = r_drain_cnt + DRAIN_CNT_W'(1);
                    w_map_update_nxt = (w_drain_cnt_nxt == DRAIN_LAST);
                end
            end
            ST_CLR: begin
                if (r_clr_addr == ADDR_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_we_nxt   = 1'b1;
                    w_clr_addr_nxt = r_clr_addr + HIST_RAM_AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // EOF outside IDLE is dropped and reported; the sequence carries on.
        if (w_eof && (r_state != ST_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_field_d1   <= 1'b0;
            r_fin_bank   <= 1'b0;
            r_drain_cnt  <= '0;
            r_bank_sel   <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_clr_we     <= 1'b0;
            r_clr_bank   <= 1'b0;
            r_clr_addr   <= '0;
            r_map_update <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_field_d1   <= i_field_vld;
            r_fin_bank   <= w_fin_bank_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_bank_sel   <= w_bank_sel_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_clr_we     <= w_clr_we_nxt;
            r_clr_bank   <= w_clr_bank_nxt;
            r_clr_addr   <= w_clr_addr_nxt;
            r_map_update <= w_map_update_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    zrc_vld_shift #(
        .LAT (RAM_RD_LAT)
    ) u_rd_vld (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (r_rd_en),
        .o_q   (w_rd_vld)
    );

    assign o_bank_sel     = r_bank_sel;
    assign o_hist_rd_en   = r_rd_en;
    assign o_hist_rd_addr = r_rd_addr;
    assign o_hist_rd_vld  = w_rd_vld;
    assign o_clr_we       = r_clr_we;
    assign o_clr_bank     = r_clr_bank;
    assign o_clr_addr     = r_clr_addr;
    assign o_map_update   = r_map_update;
    assign o_overrun      = r_overrun;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_zrc_hist_seq_ctrl.sv
// Bench for zrc_hist_seq_ctrl: per-cycle timeline model plus scenario table.
module tb_zrc_hist_seq_ctrl;

    localparam int unsigned AW  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned DC  = 5;
    localparam int          SZ  = 16;
    localparam int          N   = 6000;

    logic          clk = 1'b0;
    logic          rst, field, en, frz;
    logic          bank_sel, rd_en, rd_vld, clr_we, clr_bank, map_upd, ovr, busy;
    logic [AW-1:0] rd_addr, clr_addr;

    zrc_hist_seq_ctrl #(
        .HIST_RAM_AW (AW),
        .RAM_RD_LAT  (LAT),
        .DRAIN_CYC   (DC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_field_vld    (field),
        .i_enable       (en),
        .i_freeze       (frz),
        .o_bank_sel     (bank_sel),
        .o_hist_rd_en   (rd_en),
        .o_hist_rd_addr (rd_addr),
        .o_hist_rd_vld  (rd_vld),
        .o_clr_we       (clr_we),
        .o_clr_bank     (clr_bank),
        .o_clr_addr     (clr_addr),
        .o_map_update   (map_upd),
        .o_overrun      (ovr),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check1(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Expected outputs per cycle, scheduled when an event (reset, accepted EOF) happens.
    bit e_rd_en [N];
    int e_rd_addr [N];
    bit e_vld [N];
    bit e_clr_we [N];
    bit e_clr_bank [N];
    int e_clr_addr [N];
    bit e_map [N];
    bit e_ovr [N];
    bit e_busy [N];
    bit e_bank [N];
    bit m_bank = 1'b0;
    bit m_prev = 1'b0;
    int m_idle_from = 0;

    task automatic sched_clr(input int start, input bit bank);
        for (int i = 0; i < SZ; i++) begin
            e_clr_we[start+i]   = 1'b1;
            e_clr_bank[start+i] = bank;
            e_clr_addr[start+i] = i;
        end
    endtask

    task automatic sched_busy(input int from, input int to);
        for (int c = from; c <= to; c++) e_busy[c] = 1'b1;
    endtask

    task automatic model_step(input int k);
        bit eof;
        bit f;
        if (rst) begin
            for (int c = k + 1; c < N; c++) begin
                e_rd_en[c] = 0; e_rd_addr[c] = 0; e_vld[c] = 0; e_clr_we[c] = 0;
                e_clr_bank[c] = 0; e_clr_addr[c] = 0; e_map[c] = 0; e_ovr[c] = 0;
                e_busy[c] = 0; e_bank[c] = 0;
            end
            m_bank = 1'b0;
            m_prev = 1'b0;
            sched_clr(k + 2, 1'b0);
            sched_clr(k + 2 + SZ, 1'b1);
            m_idle_from = k + 2 + 2 * SZ;
            sched_busy(k + 2, m_idle_from - 1);
        end else begin
            eof    = m_prev & ~field;
            m_prev = field;
            if (eof && k < m_idle_from) begin
                e_ovr[k+1] = 1'b1;
            end else if (eof && en) begin
                f      = m_bank;
                m_bank = ~m_bank;
                if (frz) begin
                    sched_clr(k + 1, f);
                    m_idle_from = k + 1 + SZ;
                end else begin
                    for (int i = 0; i < SZ; i++) begin
                        e_rd_en[k+1+i]       = 1'b1;
                        e_rd_addr[k+1+i]     = i;
                        e_vld[k+1+i+int'(LAT)] = 1'b1;
                    end
                    e_map[k+SZ+int'(DC)] = 1'b1;
                    sched_clr(k + SZ + int'(DC) + 1, f);
                    m_idle_from = k + 2 * SZ + int'(DC) + 1;
                end
                sched_busy(k + 1, m_idle_from - 1);
            end
        end
        e_bank[k+1] = m_bank;
    endtask

    // Activity monitors for the scenario-level checks.
    int  mon_rd, mon_burst, mon_map, mon_ovr, mon_clr0, mon_clr1, mon_busy, mon_tog;
    bit  prev_rd = 1'b0;
    bit  prev_bank = 1'b0;

    task automatic clear_mon();
        mon_rd = 0; mon_burst = 0; mon_map = 0; mon_ovr = 0;
        mon_clr0 = 0; mon_clr1 = 0; mon_busy = 0; mon_tog = 0;
    endtask

    always @(negedge clk) begin
        if (cyc >= 2 && cyc < N) begin
            check1("bank_sel", int'(bank_sel), int'(e_bank[cyc]));
            check1("rd_en", int'(rd_en), int'(e_rd_en[cyc]));
            check1("rd_vld", int'(rd_vld), int'(e_vld[cyc]));
            check1("clr_we", int'(clr_we), int'(e_clr_we[cyc]));
            check1("map_update", int'(map_upd), int'(e_map[cyc]));
            check1("overrun", int'(ovr), int'(e_ovr[cyc]));
            check1("busy", int'(busy), int'(e_busy[cyc]));
            if (e_rd_en[cyc]) check1("rd_addr", int'(rd_addr), e_rd_addr[cyc]);
            if (e_clr_we[cyc]) begin
                check1("clr_addr", int'(clr_addr), e_clr_addr[cyc]);
                check1("clr_bank", int'(clr_bank), int'(e_clr_bank[cyc]));
            end
            mon_rd    += int'(rd_en);
            mon_burst += int'(rd_en & ~prev_rd);
            mon_map   += int'(map_upd);
            mon_ovr   += int'(ovr);
            mon_clr0  += int'(clr_we & ~clr_bank);
            mon_clr1  += int'(clr_we & clr_bank);
            mon_busy  += int'(busy);
            mon_tog   += int'(bank_sel != prev_bank);
            prev_rd   = rd_en;
            prev_bank = bank_sel;
        end
        if (cyc < N - 64) model_step(cyc);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        int cnt;
        cnt = 0;
        tick(2);
        while (busy && cnt < limit) begin
            tick(1);
            cnt++;
        end
        check1("idle_wait", int'(busy), 0);
    endtask

    typedef struct {
        int hi; bit en; bit frz;
        int tog; int rd; int map; int clr; int bsy;
    } vec_t;
    vec_t vt [5];

    initial begin
        vt[0] = '{hi: 100, en: 1'b1, frz: 1'b0, tog: 1, rd: 16, map: 1, clr: 16, bsy: 37};
        vt[1] = '{hi: 100, en: 1'b1, frz: 1'b1, tog: 1, rd: 0,  map: 0, clr: 16, bsy: 16};
        vt[2] = '{hi: 60,  en: 1'b0, frz: 1'b0, tog: 0, rd: 0,  map: 0, clr: 0,  bsy: 0};
        vt[3] = '{hi: 30,  en: 1'b0, frz: 1'b1, tog: 0, rd: 0,  map: 0, clr: 0,  bsy: 0};
        vt[4] = '{hi: 25,  en: 1'b1, frz: 1'b0, tog: 1, rd: 16, map: 1, clr: 16, bsy: 37};

        rst = 1'b1; field = 1'b0; en = 1'b0; frz = 1'b0;
        clear_mon();
        tick(4);
        check1("reset_clr_we", int'(clr_we), 0);
        check1("reset_bank_sel", int'(bank_sel), 0);
        rst = 1'b0;

        // Power-up clear of both banks.
        wait_idle(100);
        check1("init_clr_bank0", mon_clr0, SZ);
        check1("init_clr_bank1", mon_clr1, SZ);

        // Scenario table; en/frz are flipped right after EOF and must not matter.
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            en = vt[v].en; frz = vt[v].frz;
            field = 1'b1;
            tick(vt[v].hi);
            field = 1'b0;
            tick(1);
            en = ~en; frz = ~frz;
            tick(60);
            check1("tbl_toggle", mon_tog, vt[v].tog);
            check1("tbl_rd_cnt", mon_rd, vt[v].rd);
            check1("tbl_map_cnt", mon_map, vt[v].map);
            check1("tbl_clr_cnt", mon_clr0 + mon_clr1, vt[v].clr);
            check1("tbl_busy_cnt", mon_busy, vt[v].bsy);
            check1("tbl_overrun", mon_ovr, 0);
        end

        // Second EOF ten cycles into the read sweep.
        clear_mon();
        en = 1'b1; frz = 1'b0;
        field = 1'b1; tick(20);
        field = 1'b0; tick(1);
        field = 1'b1; tick(9);
        field = 1'b0;
        wait_idle(80);
        tick(2);
        check1("ovr_pulses", mon_ovr, 1);
        check1("ovr_toggle", mon_tog, 1);
        check1("ovr_rd_cnt", mon_rd, SZ);
        check1("ovr_rd_bursts", mon_burst, 1);
        check1("ovr_map", mon_map, 1);

        // Reset in the eighth cycle of the read sweep.
        field = 1'b1; tick(10);
        field = 1'b0; tick(1);
        tick(7);
        check1("pre_rst_rd_en", int'(rd_en), 1);
        rst = 1'b1;
        tick(1);
        check1("rst_rd_en", int'(rd_en), 0);
        check1("rst_map", int'(map_upd), 0);
        check1("rst_bank_sel", int'(bank_sel), 0);
        check1("rst_busy", int'(busy), 0);
        rst = 1'b0;
        clear_mon();
        wait_idle(100);
        check1("rst_reinit_bank0", mon_clr0, SZ);
        check1("rst_reinit_bank1", mon_clr1, SZ);

        // Randomized traffic against the timeline model.
        for (int it = 0; it < 50; it++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 25));
            lo = int'($urandom_range(1, 50));
            field = 1'b1;
            for (int j = 0; j < hi; j++) begin
                en  = ($urandom_range(0, 3) != 0);
                frz = ($urandom_range(0, 3) == 0);
                tick(1);
            end
            field = 1'b0;
            for (int j = 0; j < lo; j++) begin
                en  = ($urandom_range(0, 3) != 0);
                frz = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            rst = 1'b0;
        end
        tick(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(10 * (N - 100));
        $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
        $fatal(1);
    end

endmodule
